// File: rtl/usb_fx2_pkg.sv
// Shared FX2 Slave-FIFO definitions: endpoint addresses, bus width and the
// OUT-engine state encoding.
package usb_fx2_pkg;

  localparam int unsigned FX2_DATA_W   = 16;
  localparam logic [1:0]  FX2_EP2_ADDR = 2'b00;  // host->FPGA endpoint
  localparam logic [1:0]  FX2_EP6_ADDR = 2'b10;  // FPGA->host endpoint

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OE   = 2'd1,
    ST_READ = 2'd2
  } rx_state_e;

endpackage

// File: rtl/usb_stream_out_if.sv
// Valid/ready stream carrying host->FPGA words out of the OUT engine.
//   usb_rx_data  : head-of-buffer word
//   usb_rx_valid : data valid
//   usb_rx_ready : consumer accepts the word on valid&ready at the clock edge
interface usb_stream_out_if;
  import usb_fx2_pkg::*;

  logic [FX2_DATA_W-1:0] usb_rx_data;
  logic                  usb_rx_valid;
  logic                  usb_rx_ready;

  modport master (output usb_rx_data, output usb_rx_valid, input usb_rx_ready);
  modport slave  (input usb_rx_data, input usb_rx_valid, output usb_rx_ready);

endinterface

// File: rtl/usb_rx_sync_fifo.sv
// Single-clock show-ahead FIFO with an occupancy counter.
//   clk, rst_n  : clock, synchronous active-low reset (flushes pointers/count)
//   push_i      : write wdata_i (ignored when full)
//   pop_i       : drop head word (ignored when empty)
//   rdata_c_o   : head word, combinational from storage
//   usedw_o     : words held
//   full_c_o    : usedw == DEPTH
//   empty_c_o   : usedw == 0
module usb_rx_sync_fifo #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned UW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_c_o,
  output logic [UW-1:0]    usedw_o,
  output logic             full_c_o,
  output logic             empty_c_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [UW-1:0]    usedw_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_c_o  = (usedw_q == UW'(DEPTH));
  assign empty_c_o = (usedw_q == '0);
  assign push_ok   = push_i & ~full_c_o;
  assign pop_ok    = pop_i & ~empty_c_o;
  assign rdata_c_o = mem_q[rd_ptr_q];
  assign usedw_o   = usedw_q;

  // Storage needs no reset: stale entries are never visible with usedw=0.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally; occupancy is a separate counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      usedw_q <= usedw_q + UW'(1);
      else if (pop_ok && !push_ok) usedw_q <= usedw_q - UW'(1);
    end
  end

endmodule

// File: rtl/usb_stream_out.sv
// FX2 Slave-FIFO OUT engine: drains EP2 into a small buffer and presents the
// words on a valid/ready stream in the fx2_ifclk domain.
//   fx2_ifclk, reset_n      : clock, synchronous active-low reset
//   usb_rx_enable           : permission to drain EP2
//   fx2_fdata, fx2_flagb    : FD bus input side, EP2 not-empty flag
//   fx2_faddr/slrd/sloe/... : Slave-FIFO control outputs
//   usb_rx_usedw            : words held in the buffer
//   usb_rx_word_cnt         : words read from FX2 since reset (wrapping)
//   rx                      : output stream (master side)
module usb_stream_out
  import usb_fx2_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = 16,
  parameter  int unsigned CNT_W      = 32,
  localparam int unsigned USEDW_W    = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  fx2_ifclk,
  input  logic                  reset_n,
  input  logic                  usb_rx_enable,
  input  logic [FX2_DATA_W-1:0] fx2_fdata,
  input  logic                  fx2_flagb,
  output logic [1:0]            fx2_faddr,
  output logic                  fx2_slrd,
  output logic                  fx2_sloe,
  output logic                  fx2_slwr,
  output logic                  fx2_pkt_end,
  output logic                  fx2_slcs,
  output logic [USEDW_W-1:0]    usb_rx_usedw,
  output logic [CNT_W-1:0]      usb_rx_word_cnt,
  usb_stream_out_if.master      rx
);

  rx_state_e        state_q;
  logic             sloe_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             capture;

  assign fx2_faddr       = FX2_EP2_ADDR;
  assign fx2_slwr        = 1'b1;
  assign fx2_pkt_end     = 1'b1;
  assign fx2_slcs        = 1'b0;
  assign fx2_sloe        = sloe_q;
  assign usb_rx_word_cnt = word_cnt_q;

  // Strobe is combinational so a word is taken on the very edge the FX2
  // advances its pointer; full blocks it even if a pop is pending.
  assign fx2_slrd = ~((state_q == ST_READ) & fx2_flagb & ~fifo_full);
  assign capture  = ~fx2_slrd;

  // Bus FSM; sloe is registered alongside the state it belongs to.
  always_ff @(posedge fx2_ifclk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sloe_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (usb_rx_enable && fx2_flagb && !fifo_full) begin
            state_q <= ST_OE;
            sloe_q  <= 1'b0;
          end
        end
        ST_OE: begin
          if (!usb_rx_enable) begin
            state_q <= ST_IDLE;
            sloe_q  <= 1'b1;
          end else begin
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (!usb_rx_enable || !fx2_flagb) begin
            state_q <= ST_IDLE;
            sloe_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sloe_q  <= 1'b1;
        end
      endcase
    end
  end

  // Received-word statistics.
  always_ff @(posedge fx2_ifclk) begin
    if (!reset_n)     word_cnt_q <= '0;
    else if (capture) word_cnt_q <= word_cnt_q + CNT_W'(1);
  end

  usb_rx_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FX2_DATA_W)
  ) u_fifo (
    .clk       (fx2_ifclk),
    .rst_n     (reset_n),
    .push_i    (capture),
    .wdata_i   (fx2_fdata),
    .pop_i     (rx.usb_rx_valid & rx.usb_rx_ready),
    .rdata_c_o (rx.usb_rx_data),
    .usedw_o   (usb_rx_usedw),
    .full_c_o  (fifo_full),
    .empty_c_o (fifo_empty)
  );

  assign rx.usb_rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_usb_stream_out.sv
// Bench for usb_stream_out: FX2 EP2 model feeding a scoreboard, a stream
// monitor comparing delivered words, a phase table and corner-case sequences.
module tb_usb_stream_out;
  import usb_fx2_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned UW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n = 1'b0;
  logic              en      = 1'b0;
  logic [15:0]       fx2_fdata;
  logic              fx2_flagb;
  logic [1:0]        fx2_faddr;
  logic              fx2_slrd, fx2_sloe, fx2_slwr, fx2_pkt_end, fx2_slcs;
  logic [UW-1:0]     usedw;
  logic [CNT_W-1:0]  word_cnt;

  usb_stream_out_if rx_if ();

  usb_stream_out #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .fx2_ifclk       (clk),
    .reset_n         (reset_n),
    .usb_rx_enable   (en),
    .fx2_fdata       (fx2_fdata),
    .fx2_flagb       (fx2_flagb),
    .fx2_faddr       (fx2_faddr),
    .fx2_slrd        (fx2_slrd),
    .fx2_sloe        (fx2_sloe),
    .fx2_slwr        (fx2_slwr),
    .fx2_pkt_end     (fx2_pkt_end),
    .fx2_slcs        (fx2_slcs),
    .usb_rx_usedw    (usedw),
    .usb_rx_word_cnt (word_cnt),
    .rx              (rx_if)
  );

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  // FX2 EP2 model: words are handed out on every edge with slrd low.
  logic [15:0] fx_mem [1024];
  int          fx_rd    = 0;
  int          fx_end   = 0;
  logic        fx_stall = 1'b0;
  int          val      = 0;
  logic [15:0] sb [$];

  assign fx2_flagb = (fx_rd < fx_end) && !fx_stall;
  assign fx2_fdata = fx_mem[10'(fx_rd)];

  always @(posedge clk) begin
    if (!fx2_slrd && fx_rd < fx_end) begin
      if (reset_n) sb.push_back(fx_mem[10'(fx_rd)]);
      fx_rd <= fx_rd + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream monitor: every accepted word must be the oldest expected one.
  always @(negedge clk) begin
    if (reset_n && rx_if.usb_rx_valid && rx_if.usb_rx_ready) begin
      pops++;
      if (sb.size() == 0) begin
        check("stream_unexpected_word", 32'(rx_if.usb_rx_data), 32'hffff_ffff);
      end else begin
        check("stream_data", 32'(rx_if.usb_rx_data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] w);
    fx_mem[10'(fx_end)] = w;
    fx_end++;
  endtask

  task automatic load_seq(input int n);
    for (int i = 0; i < n; i++) begin
      load_word(16'(val));
      val++;
    end
  endtask

  typedef struct {
    logic rst_n; logic en; logic rdy; int load; int cyc;
    int usedw; int cnt; logic valid; logic sloe; logic slrd;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int k, lows, first, base, bad, pops0;
    rx_if.usb_rx_ready = 1'b0;

    //              rst en rdy load cyc usedw cnt valid sloe slrd
    tbl[0] = '{1'b0, 1'b1, 1'b1, 4,  3,  0,  0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 0,  12, 0,  4, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 3,  12, 3,  7, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 5,  10, 0,  7, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 0,  15, 0, 12, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 20, 40, 16, 12, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 0,  40, 0,  0, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 7; i++) begin
      reset_n = tbl[i].rst_n;
      en      = tbl[i].en;
      rx_if.usb_rx_ready = tbl[i].rdy;
      load_seq(tbl[i].load);
      for (int c = 0; c < tbl[i].cyc; c++) begin
        step();
        if (!tbl[i].rst_n) begin
          check($sformatf("row%0d_reset_slrd", i), 32'(fx2_slrd), 1);
          check($sformatf("row%0d_reset_sloe", i), 32'(fx2_sloe), 1);
          check($sformatf("row%0d_reset_valid", i), 32'(rx_if.usb_rx_valid), 0);
          check($sformatf("row%0d_reset_usedw", i), 32'(usedw), 0);
          check($sformatf("row%0d_reset_cnt", i), 32'(word_cnt), 0);
        end
      end
      check($sformatf("row%0d_usedw", i), 32'(usedw), 32'(tbl[i].usedw));
      check($sformatf("row%0d_cnt", i), 32'(word_cnt), 32'(tbl[i].cnt));
      check($sformatf("row%0d_valid", i), 32'(rx_if.usb_rx_valid), 32'(tbl[i].valid));
      check($sformatf("row%0d_sloe", i), 32'(fx2_sloe), 32'(tbl[i].sloe));
      check($sformatf("row%0d_slrd", i), 32'(fx2_slrd), 32'(tbl[i].slrd));
    end
    check("const_faddr", 32'(fx2_faddr), 32'(FX2_EP2_ADDR));
    check("const_slwr_pktend_slcs", 32'({fx2_slwr, fx2_pkt_end, fx2_slcs}), 32'b110);

    // Four-word burst: strobe timing relative to leaving IDLE.
    en = 1'b1;
    rx_if.usb_rx_ready = 1'b1;
    load_word(16'h1111); load_word(16'h2222); load_word(16'h3333); load_word(16'h4444);
    lows = 0; first = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (!fx2_slrd) begin
        if (first < 0) first = c;
        lows++;
      end
    end
    check("burst_first_slrd_cycle", 32'(first), 2);
    check("burst_slrd_cycles", 32'(lows), 4);
    check("burst_cnt", 32'(word_cnt), 4);
    check("burst_idle_sloe", 32'(fx2_sloe), 1);
    check("burst_drained", 32'(usedw), 0);

    // Backpressure: buffer fills to exactly DEPTH, then drains in order.
    rx_if.usb_rx_ready = 1'b0;
    pops0 = pops;
    load_seq(100);
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (!fx2_slrd) lows++;
    end
    check("bp_slrd_pulses", 32'(lows), 16);
    check("bp_usedw_full", 32'(usedw), 16);
    check("bp_slrd_held", 32'(fx2_slrd), 1);
    rx_if.usb_rx_ready = 1'b1;
    for (k = 0; k < 400; k++) begin
      if (fx_rd == fx_end && usedw == 0) break;
      step();
    end
    check("bp_drain_in_time", 32'(k < 400), 1);
    check("bp_words_delivered", 32'(pops - pops0), 100);
    check("bp_cnt", 32'(word_cnt), 8);

    // Enable dropped during the third READ cycle.
    rx_if.usb_rx_ready = 1'b0;
    base = fx_rd;
    load_seq(10);
    lows = 0;
    for (k = 0; k < 20; k++) begin
      step();
      if (!fx2_slrd) lows++;
      if (lows == 3) break;
    end
    check("endrop_reached_read3", 32'(k < 20), 1);
    en = 1'b0;
    step();
    check("endrop_slrd_next", 32'(fx2_slrd), 1);
    check("endrop_captured", 32'(fx_rd - base), 3);
    check("endrop_usedw", 32'(usedw), 3);
    step();
    check("endrop_sloe", 32'(fx2_sloe), 1);
    repeat (5) step();
    check("endrop_fx2_untouched", 32'(fx_rd - base), 3);
    check("endrop_cnt", 32'(word_cnt), 11);

    // Continuous push/pop: occupancy settles at one word.
    rx_if.usb_rx_ready = 1'b1;
    repeat (5) step();
    load_seq(30);
    en = 1'b1;
    lows = 0; bad = 0;
    for (k = 0; k < 100; k++) begin
      step();
      if (!fx2_slrd) begin
        lows++;
        if (lows > 1 && usedw != 1) bad++;
      end
      if (fx_rd == fx_end && usedw == 0) break;
    end
    check("pp_done_in_time", 32'(k < 100), 1);
    check("pp_reads", 32'(lows), 37);
    check("pp_usedw_not_one", 32'(bad), 0);
    check("pp_cnt", 32'(word_cnt), 0);

    // Reset after five reads, then restart and wrap the 4-bit counter.
    rx_if.usb_rx_ready = 1'b0;
    base = fx_rd;
    load_seq(20);
    for (k = 0; k < 30; k++) begin
      if (fx_rd - base == 5) break;
      step();
    end
    check("rst_reached_5_reads", 32'(k < 30), 1);
    fx_stall = 1'b1;
    reset_n  = 1'b0;
    sb.delete();
    step();
    check("rst_usedw", 32'(usedw), 0);
    check("rst_valid", 32'(rx_if.usb_rx_valid), 0);
    check("rst_cnt", 32'(word_cnt), 0);
    check("rst_slrd", 32'(fx2_slrd), 1);
    check("rst_restart_word", 32'(fx_rd - base), 5);
    reset_n  = 1'b1;
    fx_stall = 1'b0;
    rx_if.usb_rx_ready = 1'b1;
    for (k = 0; k < 100; k++) begin
      if (fx_rd == fx_end && usedw == 0) break;
      step();
    end
    check("rst_drain_in_time", 32'(k < 100), 1);
    check("wrap_cnt_15", 32'(word_cnt), 15);
    load_word(16'hbeef);
    for (k = 0; k < 30; k++) begin
      if (fx_rd == fx_end && usedw == 0) break;
      step();
    end
    check("wrap_in_time", 32'(k < 30), 1);
    check("wrap_cnt_0", 32'(word_cnt), 0);
    repeat (3) step();
    check("sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
